// File: rtl/serial_demux_pkg.sv
// Shared types and sizes for the serial 1:8 demultiplexer.
package serial_demux_pkg;
    localparam int N_LANE = 8;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;
endpackage

// File: rtl/serial_demux_1x8_lane_dec.sv
// demux_lane_dec: 3-to-8 one-hot lane write-enable decoder.
// MSB_FIRST mirrors the index so the first frame bit lands on lane 7.
module demux_lane_dec
    import serial_demux_pkg::*;
#(
    parameter int MSB_FIRST = 0
) (
    input  logic [IDX_W-1:0]  idx,
    input  logic              en,
    output logic [N_LANE-1:0] lane_en
);

    logic [IDX_W-1:0] lane;

    always_comb begin
        lane    = (MSB_FIRST != 0) ? IDX_W'(N_LANE - 1) - idx : idx;
        lane_en = '0;
        if (en) lane_en[lane] = 1'b1;
    end

endmodule

// File: rtl/serial_demux_1x8.sv
// Framed bit-serial to 8-bit parallel demux with one-cycle completion strobe.
// Optional even-parity bit after data bit 7 when SERIAL_DEMUX_PARITY_EN is defined.
module serial_demux_1x8
    import serial_demux_pkg::*;
#(
    parameter int MSB_FIRST = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    input  logic        in_valid,
    input  logic        sync,
    output logic [7:0]  dout,
    output logic        out_valid,
    output logic        busy,
    output logic        frame_err,
    output logic        par_err
);

    state_t             state, state_nx;
    logic [IDX_W-1:0]   idx, idx_nx, wr_idx;
    logic [N_LANE-1:0]  shadow, shadow_nx, lane_en;
    logic               wr_en, load, abort;

    // A sync bit always restarts at lane(0), whatever idx holds.
    assign wr_idx    = sync ? '0 : idx;
    assign shadow_nx = (shadow & ~lane_en) | (lane_en & {N_LANE{sin}});
    assign busy      = (state != IDLE);

    demux_lane_dec #(.MSB_FIRST(MSB_FIRST)) u_dec (
        .idx     (wr_idx),
        .en      (wr_en),
        .lane_en (lane_en)
    );

`ifdef SERIAL_DEMUX_PARITY_EN
    logic par_acc, perr_nx;
`endif

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        wr_en    = 1'b0;
        load     = 1'b0;
        abort    = 1'b0;
`ifdef SERIAL_DEMUX_PARITY_EN
        perr_nx  = 1'b0;
`endif
        case (state)
            IDLE: if (in_valid && sync) begin
                wr_en    = 1'b1;
                idx_nx   = IDX_W'(1);
                state_nx = RECV;
            end
            RECV: if (in_valid) begin
                wr_en = 1'b1;
                if (sync) begin
                    abort  = 1'b1;
                    idx_nx = IDX_W'(1);
                end else begin
                    idx_nx = idx + IDX_W'(1);
                    if (idx == IDX_W'(N_LANE - 1)) begin
`ifdef SERIAL_DEMUX_PARITY_EN
                        state_nx = PAR;
`else
                        load     = 1'b1;
                        state_nx = IDLE;
`endif
                    end
                end
            end
`ifdef SERIAL_DEMUX_PARITY_EN
            PAR: if (in_valid) begin
                if (sync) begin
                    abort    = 1'b1;
                    wr_en    = 1'b1;
                    idx_nx   = IDX_W'(1);
                    state_nx = RECV;
                end else begin
                    load     = 1'b1;
                    perr_nx  = (par_acc != sin);
                    state_nx = IDLE;
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            shadow    <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            idx       <= idx_nx;
            shadow    <= shadow_nx;
            out_valid <= load;
            frame_err <= abort;
            // In PAR no lane is written, so shadow_nx equals the finished word.
            if (load) dout <= shadow_nx;
        end
    end

`ifdef SERIAL_DEMUX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_acc <= 1'b0;
            par_err <= 1'b0;
        end else begin
            if (wr_en) par_acc <= sync ? sin : (par_acc ^ sin);
            par_err <= perr_nx;
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: doc/serial_demux_1x8.md
# serial_demux_1x8

- Receives a framed, bit-serial stream and routes each successive bit to one of eight output lanes, selected by an internal 3-bit index.
- Presents the completed 8-bit word with a one-cycle valid strobe.
- It is the receive-side counterpart of our 8:1 selection logic: the mux picks one of eight bits by index; this block fans one stream back out to eight bits by index, sequentially.
- It sits between a serial link and downstream 8-bit parallel consumers.

## Interface
Parameters:
- MSB_FIRST, default 0: 0 means the first frame bit lands on dout[0]; 1 means it lands on dout[7].

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- sin  input  1  serial data bit
- in_valid  input  1  sin is meaningful this cycle; when low, the block stalls
- sync  input  1  qualified by in_valid; marks the first bit of a frame
- dout  output  8  last completed word
- out_valid  output  1  one-cycle strobe; dout is new
- busy  output  1  a frame is in progress
- frame_err  output  1  one-cycle strobe; frame aborted by an early sync
- par_err  output  1  one-cycle strobe; parity mismatch (see Configuration)

## Operation
- States: IDLE, RECV, PAR. PAR exists only with the macro.
- Accepted bit: any cycle with in_valid=1. Cycles with in_valid=0 change nothing.
- Routing index: idx, 3 bits. Lane = idx when MSB_FIRST=0; lane = 7-idx when MSB_FIRST=1.
- IDLE:
  - Accepted bit with sync=0 is discarded.
  - Accepted bit with sync=1: write sin into shadow lane(0), set idx=1, go to RECV.
- RECV, accepted bit with sync=0:
  - Write sin into shadow lane(idx), then idx+1.
  - When idx==7, write the bit and then:
    - without the macro: copy shadow (including this bit) to dout, pulse out_valid, go to IDLE;
    - with the macro: go to PAR.
- RECV, accepted bit with sync=1:
  - Pulse frame_err.
  - Treat the bit as lane(0) of a new frame, set idx=1, stay in RECV. The old partial word is never output.
- idx does not wrap: leaving RECV at idx==7 ends the frame. No data beyond 8 bits is captured.
- dout holds its value between frames. Only a completed frame updates it.
- busy = (state != IDLE).

## Timing
- Reset values: dout=8'h00, out_valid=0, busy=0, frame_err=0, par_err=0. Also state=IDLE, idx=0, shadow=0.
- Reset asserted mid-frame discards the partial word. No strobe is produced.
- Latency: out_valid and the new dout are visible the cycle after the edge that accepts the last bit (bit 7, or the parity bit).
- Throughput: back-to-back frames with no gap.
  - The block is in IDLE on the cycle out_valid is high.
  - A sync on that cycle starts the next frame.
  - Rate is 8 accepted bits per word, or 9 with the macro.
- All strobes last exactly one cycle. They are never asserted during stall cycles.

## Configuration
- Macro: SERIAL_DEMUX_PARITY_EN.
- Defined:
  - One extra accepted bit after data bit 7 (state PAR) carries even parity: XOR of the 8 data bits equals this bit.
  - dout updates and out_valid pulses regardless of the parity result.
  - par_err pulses in the same cycle as out_valid on mismatch.
  - sync=1 on the parity bit aborts the frame like RECV does: frame_err pulses, and the bit starts a new frame.
- Undefined: no PAR state, and par_err is tied to 0.

## Structure
- Package serial_demux_pkg holds:
  - state enum {IDLE, RECV, PAR};
  - N_LANE=8;
  - IDX_W=3.
- One sub-module, demux_lane_dec: a combinational 3-to-8 one-hot write-enable decoder (index plus enable in, 8 lane enables out).
- The top block holds the FSM, idx counter, shadow register, parity accumulator and output registers.

## Test plan
- Reset, then apply nothing: all outputs 0. Assert rst while busy=1 at idx=4: busy=0 next edge, no out_valid.
- MSB_FIRST=0, contiguous frame sin=1,0,1,1,0,0,1,0 (sync on the first bit) -> dout=8'h4D, single out_valid pulse one cycle after the 8th bit.
- Same stream with MSB_FIRST=1 -> dout=8'hB2.
- Same frame with in_valid dropped for 3 cycles after bit 3 -> dout=8'h4D, out_valid delayed 3 cycles, busy held at 1 during the stall.
- sync re-asserted on bit 5, followed by a full frame of 8'hFF -> frame_err pulse at bit 5, then dout=8'hFF, exactly one out_valid; 8'h4D never appears.
- With SERIAL_DEMUX_PARITY_EN: 8'h4D frame with parity bit 0 -> out_valid, par_err=0. Repeat with parity bit 1 -> out_valid with par_err=1, dout=8'h4D. Two back-to-back frames give strobes 9 cycles apart.
